// File: rtl/sn74xx_scan_mux_pkg.sv
// Shared definitions for the sn74xx strobed/registered multiplexer models:
// mode encoding, a constant clog2 and the strobe inactive-level helper.
package sn74xx_scan_mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Inactive output bit level: 1 for inverting parts, 0 for true-output parts.
  function automatic logic inact_bit(input int invert);
    return (invert != 0) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/sn74xx_dwell_counter.sv
// Dwell counter for scan mode: counts clocks spent on the current channel
// and flags the step to the next channel, plus the wrap back to channel 0.
module sn74xx_dwell_counter
  import sn74xx_scan_mux_pkg::*;
#(
  parameter int DWELL    = 4,
  parameter int CHANNELS = 4,
  localparam int SELW    = clog2(CHANNELS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            restart,
  input  logic [SELW-1:0] ch,
  output logic            step,
  output logic            wrap
);

  localparam int CNTW = (DWELL > 1) ? clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
  localparam logic [SELW-1:0] CH_LAST  = SELW'(CHANNELS - 1);

  logic [CNTW-1:0] cnt_r;

  // Step when the dwell on this channel ends; wrap only when leaving the last real channel.
  always_comb begin
    step = 1'b0;
    wrap = 1'b0;
    if (en && (cnt_r == CNT_LAST)) begin
      step = 1'b1;
      wrap = (ch == CH_LAST) ? 1'b1 : 1'b0;
    end else begin
      step = 1'b0;
      wrap = 1'b0;
    end
  end

  // Dwell position: advances in scan, clears in manual, frozen while held.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNTW{1'b0}};
    end else if (en) begin
      cnt_r <= (cnt_r == CNT_LAST) ? {CNTW{1'b0}} : cnt_r + 1'b1;
    end else if (restart) begin
      cnt_r <= {CNTW{1'b0}};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/sn74xx_scan_mux.sv
// Registered N-channel, W-bit multiplexer with strobe, optional output
// inversion and an auto-scan mode with programmable dwell per channel.
module sn74xx_scan_mux
  import sn74xx_scan_mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4,
  parameter int INVERT   = 0,
  localparam int SELW    = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SELW-1:0]           sel,
  input  logic                      str,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out,
  output logic [SELW-1:0]           ch,
  output logic                      wrap
);

  localparam logic [WIDTH-1:0] INACT   = {WIDTH{inact_bit(INVERT)}};
  localparam logic [SELW-1:0]  CH_LAST = SELW'(CHANNELS - 1);

  logic             scan_s;
  logic             en_s;
  logic             restart_s;
  logic             step_s;
  logic             wrap_s;
  logic [SELW-1:0]  nch_s;
  logic [WIDTH-1:0] data_s;
  logic             found_s;
  logic [WIDTH-1:0] next_out_s;

  assign scan_s    = (mode == MODE_SCAN) ? 1'b1 : 1'b0;
  assign en_s      = scan_s & ~hold;
  assign restart_s = ~scan_s & ~hold;

  sn74xx_dwell_counter #(
    .DWELL    (DWELL),
    .CHANNELS (CHANNELS)
  ) u_dwell (
    .clk     (clk),
    .rst     (rst),
    .en      (en_s),
    .restart (restart_s),
    .ch      (ch),
    .step    (step_s),
    .wrap    (wrap_s)
  );

  // Next channel: sel in manual mode; in scan, advance on step and fold any
  // out-of-range leftover channel back to 0.
  always_comb begin
    nch_s = ch;
    if (scan_s) begin
      if (step_s) begin
        nch_s = (ch >= CH_LAST) ? {SELW{1'b0}} : ch + 1'b1;
      end else begin
        nch_s = ch;
      end
    end else begin
      nch_s = sel;
    end
  end

  // Channel data select; a channel number with no input yields the inactive level.
  always_comb begin
    data_s  = INACT;
    found_s = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (nch_s == SELW'(k)) begin
        data_s  = din[k*WIDTH +: WIDTH];
        found_s = 1'b1;
      end else begin
        data_s  = data_s;
        found_s = found_s;
      end
    end
  end

  // Strobe and inversion applied ahead of the output register.
  always_comb begin
    next_out_s = INACT;
    if (str || !found_s) begin
      next_out_s = INACT;
    end else if (INVERT != 0) begin
      next_out_s = ~data_s;
    end else begin
      next_out_s = data_s;
    end
  end

  // Output register: out and ch always load together so they stay consistent.
  always_ff @(posedge clk) begin
    if (rst) begin
      out  <= INACT;
      ch   <= {SELW{1'b0}};
      wrap <= 1'b0;
    end else if (hold) begin
      out  <= out;
      ch   <= ch;
      wrap <= 1'b0;
    end else begin
      out  <= next_out_s;
      ch   <= nch_s;
      wrap <= wrap_s;
    end
  end

endmodule

// File: tb/tb_sn74xx_scan_mux.sv
// Self-checking bench: three instances (true outputs, inverted outputs,
// 3-channel DWELL=1) against a timeline-based reference model, with directed
// checks for the key scenarios and a randomized phase.
module tb_sn74xx_scan_mux;

  logic        clk = 1'b0;
  logic        rst, str, mode, hold;
  logic [1:0]  sel;
  logic [15:0] din_ab;
  logic [11:0] din_c;
  logic [3:0]  out_a, out_b, out_c;
  logic [1:0]  ch_a, ch_b, ch_c;
  logic        wrap_a, wrap_b, wrap_c;

  int total = 0;
  int bad   = 0;

  // Reference model state and per-instance configuration.
  int m_ch[3];
  int m_cnt[3];
  int m_out[3];
  int m_wrap[3];
  int NCH[3] = '{4, 4, 3};
  int DW[3]  = '{2, 2, 1};
  int INV[3] = '{0, 1, 0};

  logic [3:0] exp_a[4] = '{4'ha, 4'hf, 4'h9, 4'h3};
  logic [3:0] exp_b[4] = '{4'h5, 4'h0, 4'h6, 4'hc};
  int         seq[10]  = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  always #5 clk = ~clk;

  sn74xx_scan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL(2), .INVERT(0)) dut_a (
    .clk(clk), .rst(rst), .din(din_ab), .sel(sel), .str(str), .mode(mode),
    .hold(hold), .out(out_a), .ch(ch_a), .wrap(wrap_a));

  sn74xx_scan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL(2), .INVERT(1)) dut_b (
    .clk(clk), .rst(rst), .din(din_ab), .sel(sel), .str(str), .mode(mode),
    .hold(hold), .out(out_b), .ch(ch_b), .wrap(wrap_b));

  sn74xx_scan_mux #(.WIDTH(4), .CHANNELS(3), .DWELL(1), .INVERT(0)) dut_c (
    .clk(clk), .rst(rst), .din(din_c), .sel(sel), .str(str), .mode(mode),
    .hold(hold), .out(out_c), .ch(ch_c), .wrap(wrap_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int chan_val(input int i, input int k);
    if (i < 2) return int'(din_ab >> (k * 4)) & 15;
    else       return int'(din_c  >> (k * 4)) & 15;
  endfunction

  // Scan treated as a position on a timeline of NCH*DW clocks per sweep.
  task automatic model_edge(input int i);
    int inact;
    int nxt;
    int w;
    int p;
    int d;
    inact = (INV[i] != 0) ? 15 : 0;
    if (rst) begin
      m_ch[i] = 0; m_cnt[i] = 0; m_out[i] = inact; m_wrap[i] = 0;
    end else if (hold) begin
      m_wrap[i] = 0;
    end else begin
      w = 0;
      if (!mode) begin
        nxt = int'(sel);
        m_cnt[i] = 0;
      end else if (m_ch[i] >= NCH[i]) begin
        if (m_cnt[i] == DW[i] - 1) begin nxt = 0; m_cnt[i] = 0; end
        else begin nxt = m_ch[i]; m_cnt[i] = m_cnt[i] + 1; end
      end else begin
        p = m_ch[i] * DW[i] + m_cnt[i] + 1;
        if (p == NCH[i] * DW[i]) begin p = 0; w = 1; end
        nxt = p / DW[i];
        m_cnt[i] = p % DW[i];
      end
      m_ch[i] = nxt;
      m_wrap[i] = w;
      if (str || nxt >= NCH[i]) begin
        m_out[i] = inact;
      end else begin
        d = chan_val(i, nxt);
        m_out[i] = (INV[i] != 0) ? ((~d) & 15) : d;
      end
    end
  endtask

  // One clock: update the model at the edge, then compare all instances just after it.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i);
    #1;
    chk("a.out",  32'(out_a),  m_out[0]);
    chk("a.ch",   32'(ch_a),   m_ch[0]);
    chk("a.wrap", 32'(wrap_a), m_wrap[0]);
    chk("b.out",  32'(out_b),  m_out[1]);
    chk("b.ch",   32'(ch_b),   m_ch[1]);
    chk("b.wrap", 32'(wrap_b), m_wrap[1]);
    chk("c.out",  32'(out_c),  m_out[2]);
    chk("c.ch",   32'(ch_c),   m_ch[2]);
    chk("c.wrap", 32'(wrap_c), m_wrap[2]);
  endtask

  initial begin
    din_ab = {4'h3, 4'h9, 4'hf, 4'ha};
    din_c  = {4'h9, 4'hf, 4'ha};
    rst = 1'b1; sel = 2'd2; str = 1'b0; mode = 1'b0; hold = 1'b0;

    // Reset
    tick(); tick();
    chk("rst.out_a", 32'(out_a), 32'h0);
    chk("rst.out_b", 32'(out_b), 32'hf);
    chk("rst.ch_a",  32'(ch_a),  32'h0);
    chk("rst.wrap",  32'(wrap_a), 32'h0);
    rst = 1'b0;

    // Manual sweep
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick();
      chk("sweep.out_a", 32'(out_a), 32'(exp_a[s]));
      chk("sweep.out_b", 32'(out_b), 32'(exp_b[s]));
      chk("sweep.ch_a",  32'(ch_a),  32'(s));
    end

    // Strobe for one clock
    sel = 2'd1; tick();
    str = 1'b1; tick();
    chk("strobe.on.out", 32'(out_a), 32'h0);
    chk("strobe.on.ch",  32'(ch_a),  32'h1);
    str = 1'b0; tick();
    chk("strobe.off.out", 32'(out_a), 32'hf);
    chk("strobe.off.ch",  32'(ch_a),  32'h1);

    // Scan from ch 0
    sel = 2'd0; tick();
    chk("scan.start.ch", 32'(ch_a), 32'(seq[0]));
    mode = 1'b1;
    for (int j = 1; j < 10; j++) begin
      tick();
      chk("scan.ch",   32'(ch_a),   32'(seq[j]));
      chk("scan.out",  32'(out_a),  32'(exp_a[seq[j]]));
      chk("scan.wrap", 32'(wrap_a), (j == 8) ? 32'h1 : 32'h0);
    end
    str = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("scan.str.out", 32'(out_a), 32'h0);
    end
    str = 1'b0;

    // Hold and reset mid-scan
    rst = 1'b1; tick(); rst = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    chk("hold.pre.ch", 32'(ch_a), 32'h2);
    hold = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("hold.ch",   32'(ch_a),   32'h2);
      chk("hold.out",  32'(out_a),  32'h9);
      chk("hold.wrap", 32'(wrap_a), 32'h0);
    end
    hold = 1'b0; tick();
    chk("hold.release.ch", 32'(ch_a), 32'h3);
    rst = 1'b1; tick();
    chk("midrst.ch",   32'(ch_a),   32'h0);
    chk("midrst.out",  32'(out_a),  32'h0);
    chk("midrst.wrap", 32'(wrap_a), 32'h0);
    rst = 1'b0;

    // Three channels, DWELL=1: out-of-range select then scan
    mode = 1'b0; sel = 2'd3; tick();
    chk("c.oor.out", 32'(out_c), 32'h0);
    chk("c.oor.ch",  32'(ch_c),  32'h3);
    mode = 1'b1;
    tick(); chk("c.scan0.ch", 32'(ch_c), 32'h0); chk("c.scan0.wrap", 32'(wrap_c), 32'h0);
    tick(); chk("c.scan1.ch", 32'(ch_c), 32'h1); chk("c.scan1.out", 32'(out_c), 32'hf);
    tick(); chk("c.scan2.ch", 32'(ch_c), 32'h2);
    tick(); chk("c.scan3.ch", 32'(ch_c), 32'h0); chk("c.scan3.wrap", 32'(wrap_c), 32'h1);
    tick(); chk("c.scan4.wrap", 32'(wrap_c), 32'h0);

    // Randomized phase
    for (int j = 0; j < 400; j++) begin
      rst  = ($urandom_range(0, 40) == 0);
      hold = ($urandom_range(0, 7) == 0);
      str  = ($urandom_range(0, 5) == 0);
      sel  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 12) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) begin
        din_ab = 16'($urandom);
        din_c  = 12'($urandom);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
